dot_accum_pack: RTL and testbench
=================================

Name: dot_accum_pack

Overview:
Downstream stage of the 16-lane vec_dot unit in the PE1X64_64X64 array.
- Accumulates NUM_CHUNKS successive 16-bit partial dot products (16-element slices of a 64-element row) plus a per-element bias into one Q4.11 result.
- Saturates the result and packs NUM_OUT results into one output vector with a valid/ready handshake.
- Restarts the upstream dot unit after each partial via a one-cycle clear pulse.

Parameters:
- DATA_W, 16, fixed-point word width (1-4-11 format).
- NUM_CHUNKS, 4, partials summed per output element.
- NUM_OUT, 64, output elements packed per out_vec.
- ACC_W, 20, signed accumulator width; must be >= DATA_W + clog2(NUM_CHUNKS+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  16  signed partial from the dot unit (dot_out).
- in_finish  in  1  level; partial on in_data is valid while high.
- bias_in  in  16  signed Q4.11 bias for the current element; sampled on chunk 0 accept.
- elem_idx  out  clog2(NUM_OUT)  index of the element being accumulated; used as the bias address.
- dot_clr  out  1  registered one-cycle restart pulse to the dot unit.
- out_vec  out  16*NUM_OUT  packed results; element 0 in bits [16*NUM_OUT-1 -: 16], MSB-first.
- out_valid  out  1  out_vec complete; held until accepted.
- out_ready  in  1  consumer accepts out_vec.

Behaviour:
- Reset (rst=0, async): state=S_WAIT; acc, chunk_cnt, elem_cnt (= elem_idx) all 0; out_vec=0; out_valid=0; dot_clr=0.
- FSM states: S_WAIT, S_CLR, S_WRITE, S_FULL. dot_clr = (state==S_CLR); out_valid = (state==S_FULL); both are registered.
- S_WAIT: if in_finish=1, accept:
  - acc <= (chunk_cnt==0 ? sext(bias_in) : acc) + sext(in_data).
  - chunk_cnt++ (wraps to 0 after NUM_CHUNKS-1).
  - Go to S_CLR.
- S_CLR: dot_clr=1 for exactly one cycle; in_finish is ignored. The upstream unit guarantees in_finish is low by the following cycle. Next state is S_WRITE if the accepted chunk was NUM_CHUNKS-1, else S_WAIT.
- S_WRITE:
  - Slot elem_cnt of out_vec <= sat(acc).
  - If elem_cnt==NUM_OUT-1: elem_cnt <= 0 and go to S_FULL.
  - Otherwise elem_cnt++ and go to S_WAIT.
- S_FULL: out_vec is stable and in_finish is ignored, with no dot_clr, so upstream back-pressure holds. On out_ready=1, go to S_WAIT.
- Latency: an element is written 3 cycles after its last accept (accept, S_CLR, S_WRITE). out_valid rises the cycle after the last S_WRITE.
- Saturation: sat(x) = 0x7FFF if x > 32767; 0x8000 if x < -32768; else x[15:0]. Applied once, on the final sum only; no intermediate wrap because ACC_W is sized for all terms.
- out_ready while out_valid=0 is ignored. out_vec is retained after handshake until each slot is overwritten.
- Reset mid-operation discards all partial sums; the next accept is treated as chunk 0 of element 0.

Optional Feature:
- Macro DOT_ACCUM_RELU_EN.
- When defined: S_WRITE stores max(sat(acc), 0), i.e. negative results are written as 0x0000.
- When undefined: the signed saturated value is stored unchanged.
- No port or timing difference either way.

Decomposition:
- Package dot_pkg holds:
  - DATA_W=16, FRAC_BITS=11, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
  - The state encoding (2-bit localparams S_WAIT=0, S_CLR=1, S_WRITE=2, S_FULL=3).
- One sub-module, sat_q4_11: combinational ACC_W-to-16 saturator plus the optional ReLU, parameterised on ACC_W.

Test Plan:
- Basic sum: bias 0x0400, four partials 0x0800 -> slot 0 = 0x2400 (4.5). dot_clr pulses once per accept, exactly one cycle each.
- Positive saturation: bias 0, four partials 0x7000 -> slot = 0x7FFF.
- Negative saturation: four partials 0x9000 -> slot = 0x8000 without the macro, 0x0000 with DOT_ACCUM_RELU_EN.
- Full vector with back-pressure:
  - Stimulus: element i gets bias i, partials 0; hold out_ready=0 for 10 cycles after out_valid; keep in_finish=1 throughout.
  - Response: out_vec slot i = i, element 0 at MSB; out_valid stays high; no dot_clr and no accept during the hold; on out_ready=1, elem_idx restarts at 0.
- Level handling: keep in_finish high through S_CLR -> exactly one accept per partial, not two.
- Reset mid-operation: drive rst=0 after 2 chunks of element 5 -> all outputs 0 immediately (async). The next 4 accepts form element 0 using a fresh bias.

Source files
------------

// File: rtl/dot_accum_pack_pkg.sv
// Shared word format, saturation limits and FSM encoding for dot_accum_pack.
package dot_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 11;

   localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_CLR   = 2'd1,
      S_WRITE = 2'd2,
      S_FULL  = 2'd3
   } state_t;

endpackage

// File: rtl/dot_accum_pack_if.sv
// Packed result vector with valid/ready handshake toward the consumer.
interface dot_accum_pack_if
   import dot_pkg::*;
#(
   parameter int NUM_OUT = 64
);
   logic [DATA_W*NUM_OUT-1:0] out_vec;
   logic                      out_valid;
   logic                      out_ready;

   modport master (output out_vec, output out_valid, input out_ready);
   modport slave  (input out_vec, input out_valid, output out_ready);
endinterface

// File: rtl/dot_accum_pack_sat.sv
// ACC_W-to-Q4.11 saturator; DOT_ACCUM_RELU_EN additionally clamps negatives to zero.
module sat_q4_11
   import dot_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic        [DATA_W-1:0] res
);
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] LO = ~HI;

   logic [DATA_W-1:0] sat;

   always_comb begin
      sat = acc[DATA_W-1:0];
      if (acc > HI)      sat = SAT_MAX;
      else if (acc < LO) sat = SAT_MIN;
   end

`ifdef DOT_ACCUM_RELU_EN
   assign res = sat[DATA_W-1] ? '0 : sat;
`else
   assign res = sat;
`endif

endmodule

// File: rtl/dot_accum_pack.sv
// Sums NUM_CHUNKS partial dot products plus bias per element, saturates, and packs
// NUM_OUT results into one handshaked vector. Optional macro: DOT_ACCUM_RELU_EN.
module dot_accum_pack
   import dot_pkg::*;
#(
   parameter int NUM_CHUNKS = 4,
   parameter int NUM_OUT    = 64,
   parameter int ACC_W      = 20,
   localparam int IDX_W     = $clog2(NUM_OUT),
   localparam int CNT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_finish,
   input  logic signed [DATA_W-1:0] bias_in,
   output logic        [IDX_W-1:0]  elem_idx,
   output logic                     dot_clr,
   dot_accum_pack_if.master         bus
);
   state_t state, state_nxt;

   logic signed [ACC_W-1:0]          acc;
   logic        [CNT_W-1:0]          chunk_cnt;
   logic        [IDX_W-1:0]          elem_cnt;
   logic [NUM_OUT-1:0][DATA_W-1:0]   vec_q;
   logic                             valid_q;
   logic [DATA_W-1:0]                sat_res;

   logic accept, write, last_elem;
   logic signed [ACC_W-1:0] bias_ext, data_ext;

   assign accept    = (state == S_WAIT) && in_finish;
   assign write     = (state == S_WRITE);
   assign last_elem = (elem_cnt == IDX_W'(NUM_OUT - 1));
   assign bias_ext  = {{(ACC_W-DATA_W){bias_in[DATA_W-1]}}, bias_in};
   assign data_ext  = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:  if (in_finish) state_nxt = S_CLR;
         // chunk_cnt has already wrapped when the final chunk was taken
         S_CLR:   state_nxt = (chunk_cnt == '0) ? S_WRITE : S_WAIT;
         S_WRITE: state_nxt = last_elem ? S_FULL : S_WAIT;
         S_FULL:  if (bus.out_ready) state_nxt = S_WAIT;
         default: state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_WAIT;
         dot_clr <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         dot_clr <= (state_nxt == S_CLR);
         valid_q <= (state_nxt == S_FULL);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         chunk_cnt <= '0;
      end else if (accept) begin
         acc       <= ((chunk_cnt == '0) ? bias_ext : acc) + data_ext;
         chunk_cnt <= (chunk_cnt == CNT_W'(NUM_CHUNKS - 1)) ? '0 : chunk_cnt + CNT_W'(1);
      end
   end

   // element 0 lives in the top slot, so slot index counts down from NUM_OUT-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elem_cnt <= '0;
         vec_q    <= '0;
      end else if (write) begin
         vec_q[IDX_W'(NUM_OUT - 1) - elem_cnt] <= sat_res;
         elem_cnt <= last_elem ? '0 : elem_cnt + IDX_W'(1);
      end
   end

   sat_q4_11 #(.ACC_W(ACC_W)) u_sat (
      .acc (acc),
      .res (sat_res)
   );

   assign elem_idx      = elem_cnt;
   assign bus.out_vec   = vec_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_dot_accum_pack.sv
// Directed table-driven bench for dot_accum_pack with a bias memory addressed by elem_idx.
module tb_dot_accum_pack;
   import dot_pkg::*;

   localparam int NO = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] in_data;
   logic               in_finish;
   logic signed [15:0] bias_in;
   logic [5:0]         elem_idx;
   logic               dot_clr;

   logic [15:0] bias_mem [NO];
   logic [15:0] mdl      [NO];

   dot_accum_pack_if #(.NUM_OUT(NO)) bus ();

   dot_accum_pack #(.NUM_CHUNKS(4), .NUM_OUT(NO), .ACC_W(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_finish (in_finish),
      .bias_in   (bias_in),
      .elem_idx  (elem_idx),
      .dot_clr   (dot_clr),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   assign bias_in = bias_mem[elem_idx];

   int   total = 0;
   int   bad   = 0;
   int   clr_cnt = 0;
   logic clr_d = 1'b0;

   // dot_clr must be a lone one-cycle pulse and never appear while the vector is held
   always @(negedge clk) begin
      if (dot_clr) clr_cnt++;
      if (rst) begin
         total++;
         if ((clr_d && dot_clr) || (dot_clr && bus.out_valid)) begin
            bad++;
            $display("FAIL clr_pulse act clr_d=%0b clr=%0b valid=%0b req lone pulse",
                     clr_d, dot_clr, bus.out_valid);
         end
      end
      clr_d = dot_clr;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h req=%h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] slot(input int i);
      return bus.out_vec[16*(NO-i)-1 -: 16];
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_clr();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!dot_clr && n < 20);
      chk("clr_seen", {31'd0, dot_clr}, 32'd1);
   endtask

   // in_finish stays high through S_CLR on purpose; only one accept may result
   task automatic feed(input int n, input logic [3:0][15:0] p);
      for (int k = 0; k < n; k++) begin
         in_data   = p[k];
         in_finish = 1'b1;
         wait_clr();
      end
   endtask

   task automatic run_elem(input int e, input logic [3:0][15:0] p, input logic [15:0] exp);
      int c0;
      chk("idx_start", {26'd0, elem_idx}, e);
      c0 = clr_cnt;
      feed(4, p);
      tick();
      in_finish = 1'b0;
      chk("accepts", clr_cnt - c0, 32'd4);
      chk("slot_early", {16'd0, slot(e)}, {16'd0, mdl[e]});
      tick();
      mdl[e] = exp;
      chk("slot", {16'd0, slot(e)}, {16'd0, exp});
      chk("idx_next", {26'd0, elem_idx}, (e + 1) % NO);
   endtask

   typedef struct {
      logic [15:0]      bias;
      logic [3:0][15:0] p;
      logic [15:0]      exp;
      logic [15:0]      exp_relu;
   } vec_t;

   localparam int NT = 9;
   vec_t tv [NT];

   initial begin
      int c0, n;
      logic [15:0] e;

      tv[0] = '{16'h0400, {4{16'h0800}}, 16'h2400, 16'h2400};
      tv[1] = '{16'h0000, {4{16'h7000}}, 16'h7FFF, 16'h7FFF};
      tv[2] = '{16'h0000, {4{16'h9000}}, 16'h8000, 16'h0000};
      tv[3] = '{16'hF000, {16'h0300, 16'h0200, 16'hFF00, 16'h0100}, 16'hF500, 16'h0000};
      tv[4] = '{16'h7FFF, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 16'h7FFF, 16'h7FFF};
      tv[5] = '{16'h8000, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'h8000, 16'h0000};
      tv[6] = '{16'h7000, {16'h0000, 16'h0000, 16'h0000, 16'h0FFF}, 16'h7FFF, 16'h7FFF};
      tv[7] = '{16'h8000, {4{16'h0000}}, 16'h8000, 16'h0000};
      tv[8] = '{16'h0000, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h000A, 16'h000A};

      rst           = 1'b0;
      in_data       = '0;
      in_finish     = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NO; i++) begin
         bias_mem[i] = 16'(i);
         mdl[i]      = '0;
      end

      repeat (2) @(negedge clk);
      chk("rst_clr", {31'd0, dot_clr}, 32'd0);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_idx", {26'd0, elem_idx}, 32'd0);
      chk("rst_vec", {31'd0, |bus.out_vec}, 32'd0);
      rst = 1'b1;
      tick();

      // table vectors; out_ready=1 while out_valid=0 must be ignored
      for (int t = 0; t < NT; t++) begin
         bias_mem[t] = tv[t].bias;
`ifdef DOT_ACCUM_RELU_EN
         e = tv[t].exp_relu;
`else
         e = tv[t].exp;
`endif
         run_elem(t, tv[t].p, e);
      end
      chk("valid_idle", {31'd0, bus.out_valid}, 32'd0);

      // fill the rest of the vector with in_finish held high, then back-pressure
      bus.out_ready = 1'b0;
      c0        = clr_cnt;
      in_data   = '0;
      in_finish = 1'b1;
      n = 0;
      while (!bus.out_valid && n < 3000) begin
         tick();
         n++;
      end
      chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("full_accepts", clr_cnt - c0, 32'd220);
      for (int i = NT; i < NO; i++) mdl[i] = 16'(i);

      for (int h = 0; h < 10; h++) begin
         tick();
         chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("hold_clr", {31'd0, dot_clr}, 32'd0);
         chk("hold_idx", {26'd0, elem_idx}, 32'd0);
      end
      for (int i = 0; i < NO; i++) chk($sformatf("vec_slot%0d", i), {16'd0, slot(i)}, {16'd0, mdl[i]});

      bus.out_ready = 1'b1;
      in_finish     = 1'b0;
      tick();
      chk("hs_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("hs_idx", {26'd0, elem_idx}, 32'd0);
      chk("hs_retain", {16'd0, slot(40)}, {16'd0, mdl[40]});

      // reset in the middle of element 5
      for (int i = 0; i < 5; i++) begin
         bias_mem[i] = 16'(i);
         run_elem(i, {4{16'h0000}}, 16'(i));
      end
      bias_mem[5] = 16'h1234;
      feed(2, {4{16'h0100}});
      tick();
      in_finish = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_clr", {31'd0, dot_clr}, 32'd0);
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_idx", {26'd0, elem_idx}, 32'd0);
      chk("mid_rst_vec", {31'd0, |bus.out_vec}, 32'd0);
      for (int i = 0; i < NO; i++) mdl[i] = '0;
      @(negedge clk);
      rst = 1'b1;
      bias_mem[0] = 16'h0100;
      tick();
      run_elem(0, {4{16'h0100}}, 16'h0500);
      chk("post_rst_slot5", {16'd0, slot(5)}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
